// File: rtl/prog_loader.sv
// Program-image loader: turns a byte stream (4-byte LE length header, then LE words)
// into sequential imem writes, holding the core until the image is complete.
module prog_loader #(
  parameter  int IMEM_DEPTH = 256,
  localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   instr_count
);

  // S_FIN is the cycle carrying the final imem write; DONE follows it.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t              state_r, state_nx_s;
  logic                in_ready_r;
  logic [1:0]          bidx_r;
  logic [31:0]         hdr_r;
  logic [31:0]         word_r;
  logic [ADDR_W:0]     widx_r;
  logic                imem_we_r;
  logic [ADDR_W-1:0]   imem_addr_r;
  logic [31:0]         imem_wdata_r;
  logic                core_hold_r;
  logic                load_done_r;
  logic                load_err_r;
  logic [ADDR_W:0]     instr_count_r;

  logic                accept_s;
  logic                last_byte_s;
  logic [31:0]         hdr_nx_s;
  logic [31:0]         word_nx_s;
  logic                last_word_s;

  assign accept_s    = in_valid && in_ready_r;
  assign last_byte_s = (bidx_r == 2'd3);
  assign hdr_nx_s    = {in_data, hdr_r[31:8]};
  assign word_nx_s   = {in_data, word_r[31:8]};
  assign last_word_s = ((widx_r + (ADDR_W+1)'(1)) == hdr_r[ADDR_W:0]);

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nx_s = S_LEN;
        else       state_nx_s = state_r;
      end
      S_LEN: begin
        if (accept_s && last_byte_s) begin
          if (hdr_nx_s == 32'd0)                    state_nx_s = S_DONE;
          else if (hdr_nx_s > 32'(IMEM_DEPTH))      state_nx_s = S_ERR;
          else                                      state_nx_s = S_DATA;
        end else begin
          state_nx_s = S_LEN;
        end
      end
      S_DATA: begin
        if (accept_s && last_byte_s && last_word_s) state_nx_s = S_FIN;
        else                                        state_nx_s = S_DATA;
      end
      S_FIN:   state_nx_s = S_DONE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s == S_LEN) || (state_nx_s == S_DATA);
    end
  end

  // Byte assembly, imem write port and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bidx_r        <= 2'd0;
      hdr_r         <= 32'd0;
      word_r        <= 32'd0;
      widx_r        <= '0;
      imem_we_r     <= 1'b0;
      imem_addr_r   <= '0;
      imem_wdata_r  <= 32'd0;
      core_hold_r   <= 1'b1;
      load_done_r   <= 1'b0;
      load_err_r    <= 1'b0;
      instr_count_r <= '0;
    end else begin
      imem_we_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            bidx_r        <= 2'd0;
            hdr_r         <= 32'd0;
            word_r        <= 32'd0;
            widx_r        <= '0;
            core_hold_r   <= 1'b1;
            load_done_r   <= 1'b0;
            load_err_r    <= 1'b0;
            instr_count_r <= '0;
          end
        end
        S_LEN: begin
          if (accept_s) begin
            hdr_r  <= hdr_nx_s;
            bidx_r <= bidx_r + 2'd1;
            if (last_byte_s) begin
              if (hdr_nx_s == 32'd0) begin
                load_done_r   <= 1'b1;
                core_hold_r   <= 1'b0;
                instr_count_r <= '0;
              end else if (hdr_nx_s > 32'(IMEM_DEPTH)) begin
                load_err_r <= 1'b1;
              end else begin
                widx_r <= '0;
              end
            end
          end
        end
        S_DATA: begin
          if (accept_s) begin
            word_r <= word_nx_s;
            bidx_r <= bidx_r + 2'd1;
            if (last_byte_s) begin
              imem_we_r    <= 1'b1;
              imem_addr_r  <= widx_r[ADDR_W-1:0];
              imem_wdata_r <= word_nx_s;
              widx_r       <= widx_r + (ADDR_W+1)'(1);
            end
          end
        end
        S_FIN: begin
          load_done_r   <= 1'b1;
          core_hold_r   <= 1'b0;
          instr_count_r <= hdr_r[ADDR_W:0];
        end
        default: begin
          core_hold_r <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign imem_we     = imem_we_r;
  assign imem_addr   = imem_addr_r;
  assign imem_wdata  = imem_wdata_r;
  assign core_hold   = core_hold_r;
  assign load_done   = load_done_r;
  assign load_err    = load_err_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed images, imem writes checked by a scoreboard monitor.
module tb_prog_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   instr_count;

  int checks = 0;
  int failures = 0;
  int nwrites = 0;
  logic [39:0] exp_q[$];
  logic [31:0] img [0:DEPTH-1];

  prog_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .load_done(load_done),
    .load_err(load_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      nwrites++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected none",
                 imem_addr, imem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          failures++;
          $display("FAIL imem_write: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                   imem_addr, imem_wdata, e[39:32], e[31:0]);
        end
      end
      if (core_hold !== 1'b1) begin
        checks++;
        failures++;
        $display("FAIL hold_during_write: got %0b expected 1", core_hold);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int t;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_max);
  endtask

  // Header, then n words from img[], each expected write queued as it is issued.
  task automatic load_image(input logic [31:0] n, input int gap_max);
    send_word(n, gap_max);
    if (n <= DEPTH) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back({8'(i), img[i]});
        send_word(img[i], gap_max);
      end
    end
  endtask

  task automatic wait_flag();
    int t;
    t = 0;
    while (!load_done && !load_err && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!load_done && !load_err) begin
      checks++;
      failures++;
      $display("FAIL flag_timeout: got done=0 err=0 expected a flag");
    end
  endtask

  task automatic set_prog();
    img[0] = 32'h00100013;
    img[1] = 32'h00200093;
    img[2] = 32'h00208133;
  endtask

  int w0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(core_hold), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);

    // T1: reset in the middle of DATA
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    rst = 1'b1;
    #1;
    chk("t1_hold", 32'(core_hold), 32'd1);
    chk("t1_ready", 32'(in_ready), 32'd0);
    chk("t1_we", 32'(imem_we), 32'd0);
    chk("t1_flags", {30'd0, load_done, load_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T2: 3-word load with exact done/hold timing
    set_prog();
    w0 = nwrites;
    pulse_start();
    load_image(32'd3, 0);
    chk("t2_we_cycle", 32'(imem_we), 32'd1);
    chk("t2_done_late", 32'(load_done), 32'd0);
    chk("t2_hold_late", 32'(core_hold), 32'd1);
    @(negedge clk);
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_hold", 32'(core_hold), 32'd0);
    chk("t2_count", 32'(instr_count), 32'd3);
    chk("t2_err", 32'(load_err), 32'd0);
    chk("t2_ready_done", 32'(in_ready), 32'd0);
    chk("t2_nwrites", 32'(nwrites - w0), 32'd3);

    // T3: same stream with gaps; a stray start mid-load must be ignored
    w0 = nwrites;
    pulse_start();
    chk("t3_done_clr", 32'(load_done), 32'd0);
    chk("t3_hold_set", 32'(core_hold), 32'd1);
    send_word(32'd3, 3);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'(i), img[i]});
      send_word(img[i], 3);
    end
    wait_flag();
    chk("t3_done", 32'(load_done), 32'd1);
    chk("t3_count", 32'(instr_count), 32'd3);
    chk("t3_nwrites", 32'(nwrites - w0), 32'd3);

    // T4: empty image
    w0 = nwrites;
    pulse_start();
    load_image(32'd0, 0);
    chk("t4_done", 32'(load_done), 32'd1);
    chk("t4_hold", 32'(core_hold), 32'd0);
    chk("t4_count", 32'(instr_count), 32'd0);
    repeat (2) @(negedge clk);
    chk("t4_nwrites", 32'(nwrites - w0), 32'd0);

    // T5: oversized header, then a valid 1-word image
    w0 = nwrites;
    pulse_start();
    load_image(32'(DEPTH + 1), 0);
    chk("t5_err", 32'(load_err), 32'd1);
    chk("t5_hold", 32'(core_hold), 32'd1);
    chk("t5_done", 32'(load_done), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_nwrites", 32'(nwrites - w0), 32'd0);
    img[0] = 32'hDEADBEEF;
    pulse_start();
    chk("t5_err_clr", 32'(load_err), 32'd0);
    load_image(32'd1, 0);
    wait_flag();
    chk("t5b_done", 32'(load_done), 32'd1);
    chk("t5b_err", 32'(load_err), 32'd0);
    chk("t5b_count", 32'(instr_count), 32'd1);

    // T6: full-depth image, word = index
    for (int i = 0; i < DEPTH; i++) img[i] = 32'(i);
    w0 = nwrites;
    pulse_start();
    load_image(32'(DEPTH), 0);
    wait_flag();
    chk("t6_done", 32'(load_done), 32'd1);
    chk("t6_hold", 32'(core_hold), 32'd0);
    chk("t6_count", 32'(instr_count), 32'(DEPTH));
    chk("t6_last_addr", 32'(imem_addr), 32'(DEPTH - 1));
    chk("t6_nwrites", 32'(nwrites - w0), 32'(DEPTH));

    @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
